fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the pipelined core. It replaces the bare PC register and next/jump mux of the single-cycle datapath. It holds the fetch PC, drives a synchronous instruction memory with one-cycle read latency, and buffers fetched instructions and their PCs in a small queue. The queue feeds decode through a valid/ready handshake. Branch/jump redirects from later stages flush all buffered and in-flight fetches. The PC saturates at a configurable limit and the fetch halts there.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage: fetch PC, 1-cycle imem, fetch queue.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int QUEUE_DEPTH   = 4,
  parameter int PC_LIMIT      = 'hfa,
  parameter int RESET_PC      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_pc,
  output logic                         imem_req,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr,
  input  logic [DATA_WIDTH-1:0]        imem_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_instr,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count,
  output logic                         halted
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDRESS_WIDTH-1:0] c_pc_limit = ADDRESS_WIDTH'(PC_LIMIT);
  localparam logic [ADDRESS_WIDTH-1:0] c_pc_reset = ADDRESS_WIDTH'(RESET_PC);
  localparam logic [ADDRESS_WIDTH-1:0] c_pc_one   = ADDRESS_WIDTH'(1);
  localparam logic [PTR_W-1:0]         c_ptr_one  = PTR_W'(1);
  localparam logic [CNT_W-1:0]         c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W:0]           c_depth    = (CNT_W+1)'(QUEUE_DEPTH);

  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  logic [ADDRESS_WIDTH-1:0] r_issued_pc;
  logic                     r_halted;
  logic                     r_inflight;
  logic                     r_kill;
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [CNT_W-1:0]         r_count;
  logic [DATA_WIDTH-1:0]    r_instr_q [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_pc_q    [QUEUE_DEPTH];

  logic [CNT_W:0]           w_credit;
  logic                     w_issue;
  logic                     w_push;
  logic                     w_pop;
  logic [ADDRESS_WIDTH-1:0] w_redirect_pc;

  // Occupied plus in-flight slots: an issue is only made when its response is
  // guaranteed a free entry, so the queue can never overflow.
  assign w_credit      = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign w_issue       = !rst && !redirect_valid && !r_halted && (w_credit < c_depth);
  assign w_push        = r_inflight && !r_kill && !redirect_valid;
  assign w_pop         = out_valid && out_ready;
  assign w_redirect_pc = (redirect_pc > c_pc_limit) ? c_pc_limit : redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= c_pc_reset;
      r_issued_pc <= '0;
      r_halted    <= 1'b0;
      r_inflight  <= 1'b0;
      r_kill      <= 1'b0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else begin
      r_kill     <= redirect_valid;
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_fetch_pc <= w_redirect_pc;
        r_halted   <= 1'b0;
      end else begin
        if (w_push) r_tail <= r_tail + c_ptr_one;
        if (w_pop)  r_head <= r_head + c_ptr_one;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_cnt_one;
          2'b01:   r_count <= r_count - c_cnt_one;
          default: r_count <= r_count;
        endcase
        if (w_issue) begin
          r_issued_pc <= r_fetch_pc;
          if (r_fetch_pc == c_pc_limit) r_halted   <= 1'b1;
          else                          r_fetch_pc <= r_fetch_pc + c_pc_one;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_q[r_tail] <= imem_data;
      r_pc_q[r_tail]    <= r_issued_pc;
    end
  end

  // Storage is not reset, so the head is masked whenever the queue is empty.
  assign out_valid   = (r_count != '0);
  assign out_instr   = out_valid ? r_instr_q[r_head] : '0;
  assign out_pc      = out_valid ? r_pc_q[r_head]    : '0;
  assign queue_count = r_count;
  assign imem_req    = w_issue;
  assign imem_addr   = r_fetch_pc;
  assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Randomised self-checking bench for fetch_unit against a queue model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [19:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_instr;
  logic [7:0]  out_pc;
  logic [2:0]  queue_count;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int  m_pc;
  bit  m_halted;
  bit  m_inflight;
  int  m_issued;
  int  q_pc[$];
  int  q_instr[$];
  bit  req_prev;
  logic [7:0] addr_prev;

  fetch_unit #(
    .DATA_WIDTH(20), .ADDRESS_WIDTH(8), .QUEUE_DEPTH(4), .PC_LIMIT('hfa), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .queue_count(queue_count), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mem_word(input logic [7:0] a);
    return 20'(a) + 20'h100;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = 0;
    m_halted   = 1'b0;
    m_inflight = 1'b0;
    m_issued   = 0;
    q_pc.delete();
    q_instr.delete();
  endtask

  // One cycle: drive at the falling edge, check before the rising edge, then
  // advance the model to the state the rising edge should produce.
  task automatic step(input bit rdy, input bit rv, input logic [7:0] rp);
    bit exp_req;
    bit pop;
    @(negedge clk);
    rst            = 1'b0;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_data      = req_prev ? mem_word(addr_prev) : 20'($urandom);
    #1;
    exp_req = !rv && !m_halted && ((q_pc.size() + int'(m_inflight)) < 4);
    check("imem_req", imem_req, exp_req);
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", out_valid, q_pc.size() != 0);
    check("queue_count", queue_count, q_pc.size());
    check("halted", halted, m_halted);
    if (q_pc.size() != 0) begin
      check("out_pc", out_pc, q_pc[0]);
      check("out_instr", out_instr, q_instr[0]);
    end
    req_prev  = imem_req;
    addr_prev = imem_addr;
    pop = rdy && (q_pc.size() != 0);
    if (rv) begin
      q_pc.delete();
      q_instr.delete();
      m_pc     = (int'(rp) > 'hfa) ? 'hfa : int'(rp);
      m_halted = 1'b0;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (m_inflight) begin
        q_pc.push_back(m_issued);
        q_instr.push_back(int'(mem_word(8'(m_issued))));
      end
      if (exp_req) begin
        m_issued = m_pc;
        if (m_pc == 'hfa) m_halted = 1'b1;
        else              m_pc     = m_pc + 1;
      end
    end
    m_inflight = exp_req;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    req_prev = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_data      = '0;
    req_prev       = 1'b0;
    addr_prev      = '0;
    model_reset();
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_queue_count", queue_count, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_halted", halted, 0);

    // Streaming with decode always ready
    repeat (20) step(1'b1, 1'b0, 8'h00);

    // Back-pressure from reset: queue fills to four, then drains in order
    async_reset();
    repeat (8)  step(1'b0, 1'b0, 8'h00);
    repeat (10) step(1'b1, 1'b0, 8'h00);

    // Redirect with three queued entries and one fetch in flight
    for (int i = 0; i < 10 && !(q_pc.size() == 3 && m_inflight); i++)
      step(1'b0, 1'b0, 8'h00);
    check("pre_redirect_count", q_pc.size(), 3);
    step(1'b0, 1'b1, 8'h40);
    repeat (8) step(1'b1, 1'b0, 8'h00);

    // Run into the PC limit, then resume via redirect
    step(1'b1, 1'b1, 8'hf8);
    repeat (10) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h10);
    repeat (6) step(1'b1, 1'b0, 8'h00);

    // Redirect beyond the limit is clamped
    step(1'b1, 1'b1, 8'hff);
    repeat (6) step(1'b1, 1'b0, 8'h00);

    // Random back-pressure and redirects
    repeat (2000)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 8'($urandom_range(0, 255)));

    // Asynchronous reset with two entries queued
    step(1'b0, 1'b1, 8'h20);
    for (int i = 0; i < 10 && q_pc.size() != 2; i++)
      step(1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    check("pre_reset_count", queue_count, 2);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_queue_count", queue_count, 0);
    check("async_rst_imem_req", imem_req, 0);
    model_reset();
    repeat (8) step(1'b1, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
